// File: rtl/bcd2bin_if.sv
// Handshake and result bundle between a bcd2bin converter and its requester.
interface bcd2bin_if #(
  parameter int BCD_N = 4,
  parameter int BIN_N = 14
);
  logic                 start;
  logic                 sign;
  logic [4*BCD_N-1:0]   bcd;
  logic                 ready;
  logic                 done_tick;
  logic [BIN_N-1:0]     bin;
  logic                 sign_out;
  logic                 e_digit;
  logic                 e_of;

  modport master (
    output start, sign, bcd,
    input  ready, done_tick, bin, sign_out, e_digit, e_of
  );

  modport slave (
    input  start, sign, bcd,
    output ready, done_tick, bin, sign_out, e_digit, e_of
  );
endinterface

// File: rtl/bcd2bin.sv
// Sequential signed BCD to sign-magnitude binary decoder, one digit per cycle.
// done_tick BCD_N cycles after an accepted start; start is ignored while ready=0.
module bcd2bin #(
  parameter int BCD_N = 4,
  parameter int BIN_N = 14
) (
  input  logic      clk,
  input  logic      reset_n,
  bcd2bin_if.slave  bus
);
  localparam int CNT_W = $clog2(BCD_N + 1);
  localparam int ACC_W = BIN_N + 4;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t               state, state_nxt;
  logic [4*BCD_N-1:0]   dig_sr;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 sign_reg;
  logic                 err_digit;
  logic                 err_of;

  logic [BIN_N-1:0]     bin_q;
  logic                 sign_out_q;
  logic                 e_digit_q;
  logic                 e_of_q;

  logic [3:0]           d;
  logic [ACC_W-1:0]     acc_calc;
  logic [ACC_W-1:0]     acc_nxt;
  logic                 err_digit_nxt;
  logic                 err_of_nxt;
  logic [BIN_N-1:0]     bin_final;

  logic                 rdy;
  logic                 done;
  logic                 ld;
  logic                 step;
  logic                 fin;

  // Digit datapath: acc*10 + d, frozen at its last in-range value once it overflows.
  always_comb begin
    d             = dig_sr[4*BCD_N-1 -: 4];
    acc_calc      = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, d};
    err_digit_nxt = err_digit | (d > 4'd9);
    err_of_nxt    = err_of | (acc_calc[ACC_W-1:BIN_N] != '0);
    acc_nxt       = err_of_nxt ? acc : acc_calc;
    if (err_digit_nxt) begin
      bin_final = '0;
    end else if (err_of_nxt) begin
      bin_final = '1;
    end else begin
      bin_final = acc_calc[BIN_N-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    done      = 1'b0;
    ld        = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.start) begin
          ld        = 1'b1;
          state_nxt = OP;
        end
      end
      OP: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_sr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      sign_reg   <= 1'b0;
      err_digit  <= 1'b0;
      err_of     <= 1'b0;
      bin_q      <= '0;
      sign_out_q <= 1'b0;
      e_digit_q  <= 1'b0;
      e_of_q     <= 1'b0;
    end else if (ld) begin
      dig_sr    <= bus.bcd;
      sign_reg  <= bus.sign;
      acc       <= '0;
      err_digit <= 1'b0;
      err_of    <= 1'b0;
      cnt       <= CNT_W'(BCD_N);
    end else if (step) begin
      dig_sr    <= dig_sr << 4;
      acc       <= acc_nxt;
      err_digit <= err_digit_nxt;
      err_of    <= err_of_nxt;
      cnt       <= cnt - 1'b1;
      // Results only move on the final digit so bin never shows a partial sum.
      if (fin) begin
        bin_q      <= bin_final;
        sign_out_q <= sign_reg & (|bin_final);
        e_digit_q  <= err_digit_nxt;
        e_of_q     <= ~err_digit_nxt & err_of_nxt;
      end
    end
  end

  assign bus.ready     = rdy;
  assign bus.done_tick = done;
  assign bus.bin       = bin_q;
  assign bus.sign_out  = sign_out_q;
  assign bus.e_digit   = e_digit_q;
  assign bus.e_of      = e_of_q;
endmodule

// File: tb/tb_bcd2bin.sv
// Randomized and directed bench for bcd2bin against an arithmetic decimal model (BIN_N=14 and BIN_N=10).
module tb_bcd2bin;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  bcd2bin_if #(.BCD_N(4), .BIN_N(14)) if_a();
  bcd2bin_if #(.BCD_N(4), .BIN_N(10)) if_b();

  bcd2bin #(.BCD_N(4), .BIN_N(14)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  bcd2bin #(.BCD_N(4), .BIN_N(10)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

  typedef struct packed {
    logic [7:0]  lat;
    logic [13:0] held;
    logic [13:0] bin;
    logic        s;
    logic        ed;
    logic        eo;
    logic        rdy;
  } res_t;

  int checks = 0;
  int errors = 0;
  logic [13:0] prev_a = '0;
  logic [13:0] prev_b = '0;

  function automatic res_t model(input logic [15:0] b, input logic s, input int binn,
                                 input logic [13:0] held);
    res_t r;
    int   val  = 0;
    bit   bad  = 0;
    int   maxv = (1 << binn) - 1;
    logic [3:0] nib;
    for (int i = 0; i < 4; i++) begin
      nib = b[4*i +: 4];
      if (nib > 4'd9) bad = 1;
      val += int'(nib) * (10 ** i);
    end
    r      = '0;
    r.lat  = 8'd4;
    r.held = held;
    r.rdy  = 1'b1;
    if (bad) begin
      r.bin = '0;
      r.ed  = 1'b1;
    end else if (val > maxv) begin
      r.bin = 14'(maxv);
      r.eo  = 1'b1;
    end else begin
      r.bin = 14'(val);
    end
    r.s = s && (r.bin != 0);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  // Call just after a clock edge with the selected DUT idle; returns the same way.
  task automatic conv(input bit sel, input logic [15:0] b, input logic s, output res_t r);
    int n = 0;
    r = '0;
    if (sel) begin
      if_b.bcd = b[15:0]; if_b.sign = s; if_b.start = 1'b1;
    end else begin
      if_a.bcd = b; if_a.sign = s; if_a.start = 1'b1;
    end
    @(posedge clk); #1;
    if_a.start = 1'b0; if_b.start = 1'b0;
    if_a.bcd = 16'($urandom); if_a.sign = 1'($urandom);
    if_b.bcd = 16'($urandom); if_b.sign = 1'($urandom);
    r.held = sel ? 14'(if_b.bin) : if_a.bin;
    while (n < 20 && (sel ? if_b.done_tick : if_a.done_tick) !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    r.lat = 8'(n);
    r.bin = sel ? 14'(if_b.bin) : if_a.bin;
    r.s   = sel ? if_b.sign_out : if_a.sign_out;
    r.ed  = sel ? if_b.e_digit : if_a.e_digit;
    r.eo  = sel ? if_b.e_of : if_a.e_of;
    @(posedge clk); #1;
    r.rdy = sel ? if_b.ready : if_a.ready;
  endtask

  task automatic test_reset();
    logic [18:0] exp_v = {1'b1, 1'b0, 14'd0, 3'b000};
    #5;
    checks++;
    if ({if_a.ready, if_a.done_tick, if_a.bin, if_a.sign_out, if_a.e_digit, if_a.e_of} !== exp_v) begin
      errors++;
      $display("FAIL reset_a got %h exp %h",
               {if_a.ready, if_a.done_tick, if_a.bin, if_a.sign_out, if_a.e_digit, if_a.e_of}, exp_v);
    end
    checks++;
    if ({if_b.ready, if_b.done_tick, if_b.sign_out, if_b.e_digit, if_b.e_of} !== 5'b10000 || if_b.bin !== 10'd0) begin
      errors++;
      $display("FAIL reset_b got rdy%b done%b bin%h exp rdy1 done0 bin0", if_b.ready, if_b.done_tick, if_b.bin);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_a(input string name, input logic [15:0] b, input logic s);
    res_t got, exp;
    conv(1'b0, b, s, got);
    exp = model(b, s, 14, prev_a);
    prev_a = exp.bin;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic test_overflow();
    res_t got, exp;
    logic [15:0] vals [2] = '{16'h1024, 16'h1023};
    for (int i = 0; i < 2; i++) begin
      conv(1'b1, vals[i], 1'b1, got);
      exp = model(vals[i], 1'b1, 10, prev_b);
      prev_b = exp.bin;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow_%h got %h exp %h", vals[i], got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hist [36];
    res_t        ref_r;
    logic        exp_done;
    for (int c = 0; c < 36; c++) begin
      hist[c] = c[0] ? 16'h0002 : 16'h0001;
      if_a.bcd = hist[c]; if_a.sign = 1'b0; if_a.start = 1'b1;
      @(posedge clk); #1;
      exp_done = (c % 6 == 4);
      checks++;
      if (if_a.done_tick !== exp_done) begin
        errors++;
        $display("FAIL b2b_done_c%0d got %b exp %b", c, if_a.done_tick, exp_done);
      end
      if (exp_done) begin
        ref_r = model(hist[c-4], 1'b0, 14, '0);
        checks++;
        if (if_a.bin !== ref_r.bin) begin
          errors++;
          $display("FAIL b2b_bin_c%0d got %0d exp %0d", c, if_a.bin, ref_r.bin);
        end
        prev_a = ref_r.bin;
      end
    end
    if_a.start = 1'b0;
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    logic [18:0] exp_v = {1'b1, 1'b0, 14'd0, 3'b000};
    if_a.bcd = 16'h5555; if_a.sign = 1'b1; if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if_a.ready, if_a.done_tick, if_a.bin, if_a.sign_out, if_a.e_digit, if_a.e_of} !== exp_v) begin
      errors++;
      $display("FAIL abort_async got %h exp %h",
               {if_a.ready, if_a.done_tick, if_a.bin, if_a.sign_out, if_a.e_digit, if_a.e_of}, exp_v);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    prev_a = '0;
    prev_b = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if_a.done_tick === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d exp 0", dones);
    end
    test_directed_a("after_abort_0007", 16'h0007, 1'b0);
  endtask

  task automatic test_roundtrip_edges();
    int vals [10] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999};
    res_t got, exp;
    for (int i = 0; i < 20; i++) begin
      conv(1'b0, to_bcd(vals[i % 10]), 1'(i / 10), got);
      exp = model(to_bcd(vals[i % 10]), 1'(i / 10), 14, prev_a);
      prev_a = exp.bin;
      checks++;
      if (got !== exp || got.bin != 14'(vals[i % 10])) begin
        errors++;
        $display("FAIL roundtrip_%0d_s%0d got %h exp %h", vals[i % 10], i / 10, got, exp);
      end
    end
  endtask

  task automatic test_random();
    res_t got, exp;
    logic [15:0] b;
    logic s;
    bit sel;
    for (int i = 0; i < 190; i++) begin
      sel = (i >= 150);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom);
      else b = to_bcd(int'($urandom_range(0, 9999)));
      s = 1'($urandom);
      conv(sel, b, s, got);
      exp = model(b, s, sel ? 10 : 14, sel ? prev_b : prev_a);
      if (sel) prev_b = exp.bin; else prev_a = exp.bin;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d bcd %h sign %b got %h exp %h", i, b, s, got, exp);
      end
    end
  endtask

  initial begin
    if_a.start = 1'b0; if_a.sign = 1'b0; if_a.bcd = '0;
    if_b.start = 1'b0; if_b.sign = 1'b0; if_b.bcd = '0;
    test_reset();
    test_directed_a("defaults_9999", 16'h9999, 1'b0);
    test_directed_a("neg_zero", 16'h0000, 1'b1);
    test_directed_a("neg_42", 16'h0042, 1'b1);
    test_directed_a("digit_err_12A4", 16'h12A4, 1'b0);
    test_directed_a("digit_clear_1234", 16'h1234, 1'b0);
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_roundtrip_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
- Sequential BCD-to-binary decoder, the inverse of the existing bin2bcd converter.
- Takes a signed, packed BCD value (BCD_N digits plus a sign bit) and produces a sign-magnitude binary result, matching bin2bcd's {sign, bin} format.
- Uses a start/ready/done_tick handshake so an MCU PIO pair and a tick_counter can attach the same way they do for bin2bcd.
- Used for readback and round-trip checking of display values and for decoding BCD fields received over UART.

Parameters:
- BCD_N, 4, number of BCD digits in the input.
- BIN_N, 14, magnitude width of the binary output (sign carried separately).

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only while ready=1.
- sign  input  1  sign of the input value; latched on an accepted start.
- bcd  input  4*BCD_N  packed BCD input, most-significant digit in the top nibble; latched on an accepted start.
- ready  output  1  block is idle and will accept start.
- done_tick  output  1  one-cycle pulse; result outputs are valid in this cycle.
- bin  output  BIN_N  magnitude result.
- sign_out  output  1  sign of the result.
- e_digit  output  1  at least one input nibble was greater than 9.
- e_of  output  1  magnitude exceeded 2^BIN_N-1.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE.
  - ready=1, done_tick=0, bin=0, sign_out=0, e_digit=0, e_of=0.
  - All internal registers (accumulator, digit shift register, counter, flags) are cleared.
  - Reset asserted mid-conversion aborts it immediately; no done_tick follows.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch bcd into the digit shift register and sign into a sign register; clear the accumulator and the internal error flags; load the digit counter with BCD_N; go to OP.
- OP (ready=0):
  - Each cycle takes d = top nibble of the shift register.
  - If d>9, set internal err_digit (sticky).
  - If err_of is clear: acc_next = (acc<<3) + (acc<<1) + d. The accumulator is BIN_N+4 bits wide.
  - If acc_next >= 2^BIN_N, set err_of (sticky) and freeze acc for the rest of the conversion.
  - Shift the register left by 4 and decrement the counter.
  - When the counter equals 1 this cycle, go to DONE and register the outputs on the same edge.
- Output registration on OP to DONE (evaluated in this order):
  - If err_digit: bin=0, e_digit=1, e_of=0.
  - Else if err_of: bin = all ones (saturate), e_of=1, e_digit=0.
  - Else: bin = acc_next[BIN_N-1:0], e_digit=0, e_of=0.
  - sign_out = sign_reg AND (final bin != 0). Negative zero is always reported as +0; a saturated result keeps its sign.
- DONE: ready=0, done_tick=1 for exactly one cycle; then go to IDLE.
- Timing:
  - An accepted start on edge k gives done_tick high during cycle k+BCD_N and ready high again at cycle k+BCD_N+1.
  - Throughput is one conversion per BCD_N+2 cycles with start held high.
- Output hold: bin, sign_out, e_digit and e_of hold their values from the done_tick cycle until the next conversion's DONE transition. They do not change on start.
- start while ready=0 (in OP or DONE) is ignored, not queued.
- Changes on bcd or sign after an accepted start have no effect on the running conversion.
- done_tick is a registered state decode and is glitch-free.
- bin is never written with a partial value during OP.

Test Plan:
- Defaults. Idle, then start=1 for 1 cycle with bcd=16'h9999, sign=0 -> done_tick exactly 4 cycles after the start edge; bin=14'd9999 (0x270F), sign_out=0, e_digit=0, e_of=0; ready=1 on the next cycle.
- bcd=16'h0000, sign=1 -> bin=0, sign_out=0 (no negative zero). Then bcd=16'h0042, sign=1 -> bin=42, sign_out=1.
- bcd=16'h12A4 -> e_digit=1, bin=0, e_of=0. Next conversion with bcd=16'h1234 -> bin=1234 and e_digit cleared.
- BIN_N=10 variant, bcd=16'h1024, sign=1 -> e_of=1, bin=10'h3FF, sign_out=1. Then bcd=16'h1023 -> bin=1023, e_of=0.
- Hold start=1 continuously with bcd alternating between 0x0001 and 0x0002 every cycle:
  - done_tick is exactly 6 cycles apart.
  - Each result equals the bcd value sampled on the accepting edge.
  - start during OP/DONE spawns no extra conversion.
- Assert reset_n=0 for 1 cycle during the second OP cycle of bcd=16'h5555 -> outputs go to reset values asynchronously and no done_tick appears. A subsequent start with bcd=16'h0007 -> bin=7.
- Round-trip sweep: bin2bcd (BIN_N=14) -> bcd2bin over all values 0..9999 with both signs -> output equals input, except -0 reported as +0.
